// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART receive path.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit sample counter and 3-tap majority vote.
// bit_strobe marks the tick where bit_val is resolved; bit_end marks the last tick of a bit.
module uart_rx_sampler #(
  parameter int SAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic rx,
  input  logic active,
  output logic rxs,
  output logic bit_val,
  output logic bit_strobe,
  output logic bit_end
);
  import uart_pkg::*;

  localparam int SCW = $clog2(SAMPLE);
  localparam logic [SCW-1:0] SC_A    = SCW'(SAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_B    = SCW'(SAMPLE / 2);
  localparam logic [SCW-1:0] SC_C    = SCW'(SAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SAMPLE - 1);

  logic           meta_q, meta_d;
  logic           rxs_q, rxs_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic           s0_q, s0_d;
  logic           s1_q, s1_d;

  always_comb begin
    meta_d = rx;
    rxs_d  = meta_q;
    sc_d   = sc_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    // Counter is held at zero while the FSM idles so a new start begins at sc = 0.
    if (!active) begin
      sc_d = '0;
    end else if (tick) begin
      if (sc_q == SC_A) s0_d = rxs_q;
      if (sc_q == SC_B) s1_d = rxs_q;
      sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      sc_q   <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      meta_q <= meta_d;
      rxs_q  <= rxs_d;
      sc_q   <= sc_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
    end
  end

  assign rxs        = rxs_q;
  assign bit_val    = maj3(s0_q, s1_q, rxs_q);
  assign bit_strobe = active & tick & (sc_q == SC_C);
  assign bit_end    = active & tick & (sc_q == SC_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: frame FSM, shift register, parity/framing checks and
// a one-deep valid/ready output register that drops and flags words on overrun.
module uart_rx_frame #(
  parameter int DBITS     = 8,
  parameter int SAMPLE    = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             rx,
  output logic [DBITS-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);
  import uart_pkg::*;

  rx_state_e        state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [DBITS-1:0] data_q, data_d;
  logic             pend_par_q, pend_par_d;
  logic             pend_frm_q, pend_frm_d;
  logic             armed_q, armed_d;
  logic [DBITS-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic rxs, bit_val, bit_strobe, bit_end;
  logic complete, frm_now, exp_par;

  uart_rx_sampler #(.SAMPLE(SAMPLE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .active     (busy),
    .rxs        (rxs),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  assign exp_par = (PARITY == PAR_ODD) ? ~(^data_q) : ^data_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    pend_par_d = pend_par_q;
    pend_frm_d = pend_frm_q;
    armed_d    = armed_q;
    dout_d     = dout_q;
    vld_d      = vld_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = 1'b0;
    complete   = 1'b0;
    frm_now    = pend_frm_q;

    case (state_q)
      ST_IDLE: begin
        // After a frame the line must be seen high again, so a held break is one word.
        if (rxs) armed_d = 1'b1;
        if (armed_q && !rxs) begin
          state_d    = ST_START;
          idx_d      = '0;
          pend_par_d = 1'b0;
          pend_frm_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_strobe && bit_val) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_strobe) data_d = {bit_val, data_q[DBITS-1:1]};
        if (bit_end) begin
          if (idx_q == 4'(DBITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_strobe && (bit_val != exp_par)) pend_par_d = 1'b1;
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_strobe) begin
          frm_now    = pend_frm_q | ~bit_val;
          pend_frm_d = frm_now;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
            armed_d  = 1'b0;
          end
        end
        if (bit_end && !complete) idx_d = idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      if (!vld_q || dout_ready) begin
        dout_d = data_q;
        perr_d = pend_par_q;
        ferr_d = frm_now;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
      pend_par_d = 1'b0;
      pend_frm_d = 1'b0;
    end else if (vld_q && dout_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      pend_par_q <= 1'b0;
      pend_frm_q <= 1'b0;
      armed_q    <= 1'b1;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      pend_par_q <= pend_par_d;
      pend_frm_q <= pend_frm_d;
      armed_q    <= armed_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised oversampling UART receiver with configurable word length, optional parity and one or two stop bits. Each bit is decided by a 3-sample majority vote; false starts are rejected. Received words are held in an output register with a valid/ready handshake and per-word parity and framing error flags; the block reports overrun when the consumer stalls. It sits between the baud-tick generator and the byte-stream consumer in the serial front end.

Parameters:
DBITS, 8, data bits per frame; legal range 5..9.
SAMPLE, 16, baud ticks per bit; must be even and >= 4.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits checked; 1 or 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
tick  in  1  oversample enable, one clk wide, SAMPLE ticks per bit time
rx  in  1  asynchronous serial line, idle high
dout  out  DBITS  received word, LSB = first bit on the line
dout_valid  out  1  dout holds an unconsumed word
dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready
parity_err  out  1  parity mismatch for the word in dout; valid with dout_valid; 0 when PARITY=0
frame_err  out  1  a stop bit sampled low for the word in dout; valid with dout_valid
overrun  out  1  one-clk pulse: a completed frame was dropped
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0; sample and bit counters cleared; synchroniser flops set to 1. Reset mid-frame aborts the frame; no word is delivered.
- rx passes through a 2-flop synchroniser (rxs), giving 2 clk latency; all decisions use rxs.
- Sample counter sc runs 0..SAMPLE-1, advancing only on tick; wraps to 0 at bit end.
- Majority: rxs is captured at sc = SAMPLE/2-1, SAMPLE/2 and SAMPLE/2+1. The bit value is the 2-of-3 majority, resolved on the tick where sc = SAMPLE/2+1.
- State machine:
  - IDLE: rxs == 0 -> START with sc=0.
  - START: at the majority point, value 1 -> IDLE (false start, no flags). Value 0 -> continue; at sc = SAMPLE-1 -> DATA with bit index 0.
  - DATA: the majority value is shifted into the data register MSB-first, so it ends LSB-first. After DBITS bits -> PARITY if PARITY != 0, else STOP.
  - PARITY: the majority value is compared with the XOR of the data bits (even) or its inverse (odd). A mismatch sets a pending parity error. At bit end -> STOP.
  - STOP: at each stop bit's majority point, value 0 sets a pending framing error. At the majority point of the last stop bit the frame completes and the FSM goes straight to IDLE; it does not wait for the bit end, so back-to-back frames are caught.
- Completion, registered on the clk edge after the completing tick:
  - If dout_valid=0, or dout_ready=1 in the same cycle: load dout, parity_err and frame_err from pending; dout_valid=1. Pending flags then clear.
  - Otherwise: dout and its flags are unchanged, the new word is discarded, and overrun pulses high for 1 clk.
- Handshake: dout_valid && dout_ready with no completion clears dout_valid. dout and the flags are held until overwritten.
- A frame with a framing error is still delivered.
- A line held low (break) yields word 0 with frame_err=1. The FSM then waits in IDLE for rxs=1 before accepting a new start, enforced by a rearm flag.
- The tick input is ignored in IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - parity encoding constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - a function for the majority of 3.
- One sub-module, uart_rx_sampler: synchroniser, sample counter, 3-tap capture and majority. Its outputs are bit_val, bit_strobe (majority point) and bit_end. The FSM, shift register, error logic and output handshake stay in uart_rx_frame.

Test Plan:
- DBITS=8, PARITY=0, SAMPLE=16; send 0xA5 8N1 with dout_ready=1 -> dout=0xA5, dout_valid pulses 1 clk, parity_err=0, frame_err=0.
- A 4-tick low glitch on idle rx -> FSM returns to IDLE, dout_valid stays 0, no flags.
- PARITY=1; send 0x01 with parity bit 0 -> dout=0x01, parity_err=1. Send 0x03 with parity bit 0 -> parity_err=0.
- Send 0x3C with the stop bit driven low -> dout=0x3C, frame_err=1. STOP_BITS=2 with the second stop low -> frame_err=1.
- dout_ready=0; send 0x11 then 0x22 back-to-back -> dout=0x11, overrun pulses once at the 0x22 completion. Then ready -> dout_valid=0.
- Assert rst for 1 clk mid-DATA of 0x55, then send 0x96 -> only 0x96 is delivered with no flags. Single-tick glitch at the mid-sample of each bit -> the word is still correct.
